decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  ID stage of the MIPS-lite 5-stage pipe, directly upstream of the execution stage. Decodes the
//  IF/ID instruction, reads the 32x32 register file (written back from WB), sign-extends the
//  immediate and registers everything into the ID/EX boundary feeding EX. Owns load-use stall
//  detection, branch/jump flush bubbles and the sticky HALT state.
// PARAMETERS
//  DATA          32  datapath width (mips_pkg)
//  ADDRESSWIDTH  32  PC width (mips_pkg)
//  NREGS         32  architectural registers; R0 hardwired to 0
// PORTS
//  clk          in   1        clock, all state on rising edge
//  rst_n        in   1        synchronous active-low reset
//  if_valid     in   1        IF/ID holds a real instruction
//  if_instr     in   32       [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm
//  if_pcPlus4   in   ADDRESSWIDTH  PC+4 of if_instr
//  wb_regWrite  in   1        WB write enable
//  wb_destReg   in   5        WB destination register
//  wb_data      in   DATA     WB write data
//  ex_flush     in   1        branchTaken from EX: squash the instruction in ID
//  stall        out  1        combinational; fetch and IF/ID must hold when 1
//  halted       out  1        registered, sticky after HALT is issued
//  ex_valid     out  1        ID/EX valid
//  ex_readData1 out  DATA     R[rs]
//  ex_readData2 out  DATA     R[rt]
//  ex_immOut    out  DATA     sign-extended imm[15:0]
//  ex_pcPlus4   out  ADDRESSWIDTH  passed through
//  ex_cntrl     out  Control  decoded control (rs2, aluop, jump, memRead, memWrite, regWrite, halt)
//  ex_destReg   out  5        rd for R-type, rt for I-type ALU/LDW, 0 otherwise
// BEHAVIOUR
//  - Reset: all ex_* outputs 0, ex_cntrl = NOP_CONTROL, halted=0, regfile cleared to 0.
//  - Latency: one cycle, i.e. the instruction in IF/ID at edge N is on ex_* after edge N.
//  - Regfile: write on clk when wb_regWrite && wb_destReg!=0. Writes to R0 are ignored.
//    Reads are combinational with WB bypass: same-cycle write to rs/rt returns wb_data.
//  - Decode: R-type ops (ADD, SUB, MUL, OR, AND, XOR) set rs2=0 and regWrite.
//    I-type ops (ADDI, SUBI, MULI, ORI, ANDI, XORI) set rs2=1 and regWrite.
//    LDW: rs2=1, memRead, regWrite. STW: rs2=1, memWrite.
//    BZ and BEQ: branch aluop, jump=0. JR: jump=1. HALT: halt=1.
//    Any undefined opcode is a NOP.
//  - Load-use stall = if_valid && ex_valid && ex_cntrl.memRead && ex_destReg!=0 && a match below.
//    Match: ex_destReg==rs, or ex_destReg==rt when the op reads rt (R-type, STW, BEQ).
//    On stall: ID/EX loads a bubble (ex_valid=0, NOP_CONTROL) and IF/ID is held upstream.
//  - Flush: ex_flush=1 forces the next ID/EX to a bubble regardless of if_valid. Flush wins over
//    stall, and stall is forced to 0 while ex_flush=1.
//  - HALT: when a valid HALT enters ID/EX, halted goes 1 on that edge. While halted=1 every
//    ID/EX load is a bubble and stall=0. Only rst_n clears halted. A HALT squashed by ex_flush
//    does not halt.
//  - Reset mid-operation: rst_n low overrides stall, flush and WB write in the same cycle.
//  - Bubble: ex_valid=0, ex_cntrl=NOP_CONTROL (all enables 0), data fields 0.
// STRUCTURE
//  mips_pkg gets the following additions:
//    opcode_e enum with the 18 MIPS-lite opcodes.
//    Control struct extended with memRead, memWrite, regWrite and halt.
//    NOP_CONTROL constant.
//    REGADDR=5 constant.
//  One sub-module, mips_regfile: 2 read ports, 1 write port, WB bypass, R0 fixed at 0.
//  Decoder, hazard logic and the ID/EX register live in decode_stage.
// TESTING
//  1. Write R5=0x0000_00AA via WB, then ADD R3,R5,R0 in the same cycle.
//     -> ex_readData1=0xAA (bypass), ex_destReg=3, cntrl.rs2=0.
//  2. ADDI R2,R1,0xFFFC -> ex_immOut=0xFFFF_FFFC, rs2=1, ex_destReg=2.
//     A WB write to R0 with data 0x1234 -> R0 still reads 0.
//  3. LDW R4 in ID/EX, then SUB R6,R4,R7 in ID.
//     -> stall=1 for exactly 1 cycle, one bubble, then SUB issues with R4 from WB.
//  4. LDW R4 in ID/EX, then ADDI R4,R4 and BEQ R1,R4 in ID.
//     -> the ADDI stalls (rs match).
//     -> with rt=R4 on an ADDI and LDW R0, there is no stall.
//  5. ex_flush=1 while the stall condition is true and HALT is in ID.
//     -> stall=0, bubble issued, halted stays 0.
//     Next unflushed HALT -> halted=1, all further ex_valid=0.
//  6. Assert rst_n=0 mid-stream with a pending stall.
//     -> next edge all ex_*=0, halted=0, regfile all 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-lite types: widths, opcodes, ALU ops and the decoded control bundle.
package mips_pkg;

    localparam int DATA         = 32;
    localparam int ADDRESSWIDTH = 32;
    localparam int NREGS        = 32;
    localparam int REGADDR      = 5;

    typedef enum logic [5:0] {
        OP_ADD  = 6'd0,
        OP_ADDI = 6'd1,
        OP_SUB  = 6'd2,
        OP_SUBI = 6'd3,
        OP_MUL  = 6'd4,
        OP_MULI = 6'd5,
        OP_OR   = 6'd6,
        OP_ORI  = 6'd7,
        OP_AND  = 6'd8,
        OP_ANDI = 6'd9,
        OP_XOR  = 6'd10,
        OP_XORI = 6'd11,
        OP_LDW  = 6'd12,
        OP_STW  = 6'd13,
        OP_BZ   = 6'd14,
        OP_BEQ  = 6'd15,
        OP_JR   = 6'd16,
        OP_HALT = 6'd17
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_OR  = 3'd3,
        ALU_AND = 3'd4,
        ALU_XOR = 3'd5,
        ALU_BR  = 3'd6
    } aluop_e;

    typedef struct packed {
        logic   rs2;
        aluop_e aluop;
        logic   jump;
        logic   memRead;
        logic   memWrite;
        logic   regWrite;
        logic   halt;
    } control_t;

    localparam control_t NOP_CONTROL = '{
        rs2:      1'b0,
        aluop:    ALU_ADD,
        jump:     1'b0,
        memRead:  1'b0,
        memWrite: 1'b0,
        regWrite: 1'b0,
        halt:     1'b0
    };

    function automatic aluop_e alu_for(input logic [5:0] op);
        aluop_e a;
        case (op)
            OP_SUB, OP_SUBI: a = ALU_SUB;
            OP_MUL, OP_MULI: a = ALU_MUL;
            OP_OR,  OP_ORI:  a = ALU_OR;
            OP_AND, OP_ANDI: a = ALU_AND;
            OP_XOR, OP_XORI: a = ALU_XOR;
            OP_BZ,  OP_BEQ:  a = ALU_BR;
            default:         a = ALU_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mips_regfile.sv
// 32x32 register file: two combinational read ports with WB bypass,
// one write port, R0 reads as zero.
module mips_regfile
    import mips_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REGADDR-1:0] ra1,
    input  logic [REGADDR-1:0] ra2,
    input  logic               we,
    input  logic [REGADDR-1:0] wa,
    input  logic [DATA-1:0]    wd,
    output logic [DATA-1:0]    rd1,
    output logic [DATA-1:0]    rd2
);

    logic [DATA-1:0] regs [NREGS];
    logic            wr;

    assign wr = we && (wa != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr) begin
            regs[wa] <= wd;
        end
    end

    // a same-cycle WB write is visible to the reader
    always_comb begin
        rd1 = regs[ra1];
        rd2 = regs[ra2];
        if (wr && wa == ra1) rd1 = wd;
        if (wr && wa == ra2) rd2 = wd;
        if (ra1 == '0) rd1 = '0;
        if (ra2 == '0) rd2 = '0;
    end

endmodule

// File: rtl/decode_stage.sv
// MIPS-lite ID stage: decode, regfile read, load-use stall, flush
// bubbles, sticky HALT and the ID/EX boundary register.
module decode_stage
    import mips_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_valid,
    input  logic [31:0]             if_instr,
    input  logic [ADDRESSWIDTH-1:0] if_pcPlus4,
    input  logic                    wb_regWrite,
    input  logic [REGADDR-1:0]      wb_destReg,
    input  logic [DATA-1:0]         wb_data,
    input  logic                    ex_flush,
    output logic                    stall,
    output logic                    halted,
    output logic                    ex_valid,
    output logic [DATA-1:0]         ex_readData1,
    output logic [DATA-1:0]         ex_readData2,
    output logic [DATA-1:0]         ex_immOut,
    output logic [ADDRESSWIDTH-1:0] ex_pcPlus4,
    output control_t                ex_cntrl,
    output logic [REGADDR-1:0]      ex_destReg
);

    logic [5:0]         op;
    logic [REGADDR-1:0] rs, rt, rd;
    logic [DATA-1:0]    rdata1, rdata2, imm;
    logic               is_r, is_i;
    control_t           dec;
    logic [REGADDR-1:0] dest;
    logic               uses_rt;
    logic               match, bubble;

    assign op  = if_instr[31:26];
    assign rs  = if_instr[25:21];
    assign rt  = if_instr[20:16];
    assign rd  = if_instr[15:11];
    assign imm = {{(DATA-16){if_instr[15]}}, if_instr[15:0]};

    mips_regfile u_rf (
        .clk   (clk),
        .rst_n (rst_n),
        .ra1   (rs),
        .ra2   (rt),
        .we    (wb_regWrite),
        .wa    (wb_destReg),
        .wd    (wb_data),
        .rd1   (rdata1),
        .rd2   (rdata2)
    );

    assign is_r = op inside {OP_ADD, OP_SUB, OP_MUL,
                             OP_OR, OP_AND, OP_XOR};
    assign is_i = op inside {OP_ADDI, OP_SUBI, OP_MULI,
                             OP_ORI, OP_ANDI, OP_XORI};

    always_comb begin
        dec     = NOP_CONTROL;
        dest    = '0;
        uses_rt = 1'b0;
        unique case (1'b1)
            is_r: begin
                dec.aluop    = alu_for(op);
                dec.regWrite = 1'b1;
                dest         = rd;
                uses_rt      = 1'b1;
            end
            is_i: begin
                dec.aluop    = alu_for(op);
                dec.rs2      = 1'b1;
                dec.regWrite = 1'b1;
                dest         = rt;
            end
            (op == OP_LDW): begin
                dec.rs2      = 1'b1;
                dec.memRead  = 1'b1;
                dec.regWrite = 1'b1;
                dest         = rt;
            end
            (op == OP_STW): begin
                dec.rs2      = 1'b1;
                dec.memWrite = 1'b1;
                uses_rt      = 1'b1;
            end
            (op == OP_BZ): dec.aluop = ALU_BR;
            (op == OP_BEQ): begin
                dec.aluop = ALU_BR;
                uses_rt   = 1'b1;
            end
            (op == OP_JR):   dec.jump = 1'b1;
            (op == OP_HALT): dec.halt = 1'b1;
            default: ;
        endcase
    end

    assign match = (ex_destReg == rs) || (uses_rt && ex_destReg == rt);

    // flush and halt both mask the load-use stall
    assign stall = if_valid && ex_valid && ex_cntrl.memRead &&
                   (ex_destReg != '0) && match &&
                   !ex_flush && !halted;

    assign bubble = ex_flush || halted || stall || !if_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted       <= 1'b0;
            ex_valid     <= 1'b0;
            ex_readData1 <= '0;
            ex_readData2 <= '0;
            ex_immOut    <= '0;
            ex_pcPlus4   <= '0;
            ex_cntrl     <= NOP_CONTROL;
            ex_destReg   <= '0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_readData1 <= '0;
            ex_readData2 <= '0;
            ex_immOut    <= '0;
            ex_pcPlus4   <= '0;
            ex_cntrl     <= NOP_CONTROL;
            ex_destReg   <= '0;
        end else begin
            halted       <= halted | dec.halt;
            ex_valid     <= 1'b1;
            ex_readData1 <= rdata1;
            ex_readData2 <= rdata2;
            ex_immOut    <= imm;
            ex_pcPlus4   <= if_pcPlus4;
            ex_cntrl     <= dec;
            ex_destReg   <= dest;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized bench for decode_stage against a spec-level model of the
// ID stage (register array, opcode table, hazard rules).
module tb_decode_stage;
    import mips_pkg::*;

    logic                    clk;
    logic                    rst_n;
    logic                    if_valid;
    logic [31:0]             if_instr;
    logic [ADDRESSWIDTH-1:0] if_pcPlus4;
    logic                    wb_regWrite;
    logic [REGADDR-1:0]      wb_destReg;
    logic [DATA-1:0]         wb_data;
    logic                    ex_flush;
    logic                    stall;
    logic                    halted;
    logic                    ex_valid;
    logic [DATA-1:0]         ex_readData1;
    logic [DATA-1:0]         ex_readData2;
    logic [DATA-1:0]         ex_immOut;
    logic [ADDRESSWIDTH-1:0] ex_pcPlus4;
    control_t                ex_cntrl;
    logic [REGADDR-1:0]      ex_destReg;

    decode_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pcPlus4   (if_pcPlus4),
        .wb_regWrite  (wb_regWrite),
        .wb_destReg   (wb_destReg),
        .wb_data      (wb_data),
        .ex_flush     (ex_flush),
        .stall        (stall),
        .halted       (halted),
        .ex_valid     (ex_valid),
        .ex_readData1 (ex_readData1),
        .ex_readData2 (ex_readData2),
        .ex_immOut    (ex_immOut),
        .ex_pcPlus4   (ex_pcPlus4),
        .ex_cntrl     (ex_cntrl),
        .ex_destReg   (ex_destReg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference state
    logic [31:0] m_regs [32];
    bit          m_halted;
    bit          m_valid;
    logic [31:0] m_rd1, m_rd2, m_imm, m_pc;
    control_t    m_ctl;
    logic [4:0]  m_dest;

    // dsel: 0 -> no destination, 1 -> rd, 2 -> rt
    function automatic void mdec(input logic [5:0] op, output control_t c,
                                 output bit rrt, output int dsel);
        c = NOP_CONTROL; rrt = 0; dsel = 0;
        case (op)
            OP_ADD:  begin c.aluop = ALU_ADD; c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_SUB:  begin c.aluop = ALU_SUB; c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_MUL:  begin c.aluop = ALU_MUL; c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_OR:   begin c.aluop = ALU_OR;  c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_AND:  begin c.aluop = ALU_AND; c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_XOR:  begin c.aluop = ALU_XOR; c.regWrite = 1; rrt = 1; dsel = 1; end
            OP_ADDI: begin c.aluop = ALU_ADD; c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_SUBI: begin c.aluop = ALU_SUB; c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_MULI: begin c.aluop = ALU_MUL; c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_ORI:  begin c.aluop = ALU_OR;  c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_ANDI: begin c.aluop = ALU_AND; c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_XORI: begin c.aluop = ALU_XOR; c.rs2 = 1; c.regWrite = 1; dsel = 2; end
            OP_LDW:  begin c.rs2 = 1; c.memRead = 1; c.regWrite = 1; dsel = 2; end
            OP_STW:  begin c.rs2 = 1; c.memWrite = 1; rrt = 1; end
            OP_BZ:   c.aluop = ALU_BR;
            OP_BEQ:  begin c.aluop = ALU_BR; rrt = 1; end
            OP_JR:   c.jump = 1;
            OP_HALT: c.halt = 1;
            default: ;
        endcase
    endfunction

    function automatic logic [31:0] mread(input logic [4:0] r, input bit w,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (r == 0) return 32'h0;
        if (w && wa == r) return wd;
        return m_regs[r];
    endfunction

    function automatic logic [31:0] rins(input logic [5:0] op, input int rs,
                                         input int rt, input int rd);
        logic [4:0] a, b, c;
        a = 5'(rs); b = 5'(rt); c = 5'(rd);
        return {op, a, b, c, 11'h0};
    endfunction

    function automatic logic [31:0] iins(input logic [5:0] op, input int rs,
                                         input int rt, input logic [15:0] imm);
        logic [4:0] a, b;
        a = 5'(rs); b = 5'(rt);
        return {op, a, b, imm};
    endfunction

    task automatic mreset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_halted = 0; m_valid = 0; m_ctl = NOP_CONTROL;
        m_rd1 = 0; m_rd2 = 0; m_imm = 0; m_pc = 0; m_dest = 0;
    endtask

    task automatic step(input bit rn, input bit v, input logic [31:0] ins,
                        input bit w, input logic [4:0] wa,
                        input logic [31:0] wd, input bit fl);
        control_t    c;
        bit          rrt, e_stall, bub;
        int          dsel;
        logic [4:0]  rs, rt;
        logic [31:0] pc;
        @(negedge clk);
        pc = $urandom;
        rst_n = rn; if_valid = v; if_instr = ins; if_pcPlus4 = pc;
        wb_regWrite = w; wb_destReg = wa; wb_data = wd; ex_flush = fl;
        #1;
        rs = ins[25:21]; rt = ins[20:16];
        mdec(ins[31:26], c, rrt, dsel);
        e_stall = !fl && !m_halted && v && m_valid && m_ctl.memRead &&
                  m_dest != 0 && (m_dest == rs || (rrt && m_dest == rt));
        check("stall", stall, e_stall);
        @(posedge clk);
        if (!rn) begin
            mreset();
        end else begin
            bub = fl || m_halted || e_stall || !v;
            m_valid = !bub;
            m_ctl   = bub ? NOP_CONTROL : c;
            m_rd1   = bub ? 0 : mread(rs, w, wa, wd);
            m_rd2   = bub ? 0 : mread(rt, w, wa, wd);
            m_imm   = bub ? 0 : {{16{ins[15]}}, ins[15:0]};
            m_pc    = bub ? 0 : pc;
            m_dest  = bub ? 0 : (dsel == 1 ? ins[15:11] : dsel == 2 ? rt : 5'd0);
            if (!bub && c.halt) m_halted = 1;
            if (w && wa != 0) m_regs[wa] = wd;
        end
        #1;
        check("halted", halted, m_halted);
        check("ex_valid", ex_valid, m_valid);
        check("ex_cntrl", ex_cntrl, m_ctl);
        check("ex_readData1", ex_readData1, m_rd1);
        check("ex_readData2", ex_readData2, m_rd2);
        check("ex_immOut", ex_immOut, m_imm);
        check("ex_pcPlus4", ex_pcPlus4, m_pc);
        check("ex_destReg", ex_destReg, m_dest);
    endtask

    localparam logic [31:0] NOPI = 32'hFC00_0000;

    initial begin
        logic [5:0] op;
        logic [31:0] ins;
        rst_n = 0; if_valid = 0; if_instr = 0; if_pcPlus4 = 0;
        wb_regWrite = 0; wb_destReg = 0; wb_data = 0; ex_flush = 0;
        mreset();
        repeat (2) @(posedge clk);
        step(0, 0, NOPI, 0, 0, 0, 0);

        // bypass of a same-cycle WB write
        step(1, 1, rins(OP_ADD, 5, 0, 3), 1, 5, 32'hAA, 0);
        check("t1_rd1", ex_readData1, 32'hAA);
        check("t1_dest", ex_destReg, 5'd3);
        // sign-extended imm, R0 write ignored
        step(1, 1, iins(OP_ADDI, 1, 2, 16'hFFFC), 1, 0, 32'h1234, 0);
        check("t2_imm", ex_immOut, 32'hFFFF_FFFC);
        step(1, 1, rins(OP_OR, 0, 5, 9), 0, 0, 0, 0);
        check("t2_r0", ex_readData1, 32'h0);

        // load-use on rs, one bubble, then issue with R4 from WB
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0010), 0, 0, 0, 0);
        step(1, 1, rins(OP_SUB, 4, 7, 6), 0, 0, 0, 0);
        check("t3_bubble", ex_valid, 1'b0);
        step(1, 1, rins(OP_SUB, 4, 7, 6), 1, 4, 32'hCAFE_0004, 0);
        check("t3_rd1", ex_readData1, 32'hCAFE_0004);

        // rs match on ADDI stalls; rt match on ADDI does not; BEQ rt stalls
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);
        step(1, 1, iins(OP_ADDI, 4, 4, 16'h1), 0, 0, 0, 0);
        step(1, 1, iins(OP_ADDI, 4, 4, 16'h1), 0, 0, 0, 0);
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);
        step(1, 1, iins(OP_ADDI, 1, 4, 16'h2), 0, 0, 0, 0);
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);
        step(1, 1, rins(OP_BEQ, 1, 4, 0), 0, 0, 0, 0);
        step(1, 1, iins(OP_LDW, 1, 0, 16'h0), 0, 0, 0, 0);
        step(1, 1, rins(OP_ADD, 0, 0, 1), 0, 0, 0, 0);

        // flushed HALT under a stall does not halt; the next one does
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);
        step(1, 1, rins(OP_HALT, 4, 4, 0), 0, 0, 0, 1);
        check("t5_halted0", halted, 1'b0);
        step(1, 1, rins(OP_HALT, 4, 4, 0), 0, 0, 0, 0);
        check("t5_halted1", halted, 1'b1);
        step(1, 1, rins(OP_ADD, 1, 2, 3), 1, 7, 32'h77, 0);
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);

        // reset mid-stream with a pending stall
        step(0, 1, iins(OP_LDW, 1, 4, 16'h0), 0, 0, 0, 0);
        step(1, 1, iins(OP_LDW, 1, 4, 16'h0), 1, 4, 32'h44, 0);
        step(0, 1, rins(OP_SUB, 4, 7, 6), 1, 5, 32'h55, 0);
        check("t6_valid", ex_valid, 1'b0);
        step(1, 1, rins(OP_ADD, 4, 7, 6), 0, 0, 0, 0);
        check("t6_r4", ex_readData1, 32'h0);

        for (int n = 0; n < 2000; n++) begin
            op = 6'($urandom_range(0, 19));
            if (op == OP_HALT && $urandom_range(0, 9) != 0) op = OP_ADD;
            if ($urandom_range(0, 49) == 0) op = 6'h3F;
            ins = {op, 2'b0, 3'($urandom), 2'b0, 3'($urandom),
                   2'b0, 3'($urandom), 11'($urandom)};
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 9) != 0,
                 ins,
                 $urandom_range(0, 2) == 0,
                 5'($urandom_range(0, 7)),
                 $urandom,
                 $urandom_range(0, 11) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
